// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: funct3 width codes,
// FSM state encoding and the funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_RD = 3'd2,
    WB      = 3'd3,
    FAULT   = 3'd4
  } lsu_state_e;

  // Unsigned widths exist only for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(parameter int XLEN = 32) ();

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_write;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store strobes/replication, load extraction
// with sign/zero extension, and the misaligned-or-illegal flag.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            bad
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        misaligned_s;

  // Select the addressed byte and halfword out of the read word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Per-width store lanes, load extension and alignment check
  always_comb begin
    wstrb        = 4'b0000;
    wdata        = '0;
    load_data    = '0;
    misaligned_s = 1'b0;
    case (funct3)
      F3_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{(XLEN-8){byte_s[7]}}, byte_s};
      end
      F3_H: begin
        wstrb        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata        = {2{store_data[15:0]}};
        load_data    = {{(XLEN-16){half_s[15]}}, half_s};
        misaligned_s = addr_lo[0];
      end
      F3_W: begin
        wstrb        = 4'b1111;
        wdata        = store_data;
        load_data    = rdata;
        misaligned_s = |addr_lo;
      end
      F3_BU: begin
        load_data = {{(XLEN-8){1'b0}}, byte_s};
      end
      F3_HU: begin
        load_data    = {{(XLEN-16){1'b0}}, half_s};
        misaligned_s = addr_lo[0];
      end
      default: begin
        misaligned_s = 1'b0;
      end
    endcase
    bad = misaligned_s || !f3_legal(is_store, funct3);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-aligned bus transaction,
// register-file write port driven for loads. All outputs are registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_store_data,
  input  logic [4:0]       req_rd,
  load_store_unit_if.master mem,
  output logic             write_enable,
  output logic [4:0]       write_reg,
  output logic [XLEN-1:0]  write_data,
  output logic             done,
  output logic             fault
);

  lsu_state_e      state_r;
  logic            is_store_r;
  logic [2:0]      funct3_r;
  logic [1:0]      addr_lo_r;
  logic [4:0]      rd_r;
  logic            req_ready_r, done_r, fault_r, write_enable_r;
  logic [4:0]      write_reg_r;
  logic [XLEN-1:0] write_data_r;
  logic            mem_valid_r, mem_write_r;
  logic [XLEN-1:0] mem_addr_r, mem_wdata_r;
  logic [3:0]      mem_wstrb_r;

  logic            sel_req_s;
  logic [2:0]      align_f3_s;
  logic [1:0]      align_lo_s;
  logic            align_st_s;
  logic [3:0]      wstrb_s;
  logic [XLEN-1:0] wdata_s, load_s;
  logic            bad_s;

  // In IDLE the aligner classifies the incoming request; afterwards it
  // extracts load data using the latched fields.
  assign sel_req_s  = (state_r == IDLE);
  assign align_st_s = sel_req_s ? req_is_store   : is_store_r;
  assign align_f3_s = sel_req_s ? req_funct3     : funct3_r;
  assign align_lo_s = sel_req_s ? req_addr[1:0]  : addr_lo_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_store   (align_st_s),
    .funct3     (align_f3_s),
    .addr_lo    (align_lo_s),
    .store_data (req_store_data),
    .rdata      (mem.mem_rdata),
    .wstrb      (wstrb_s),
    .wdata      (wdata_s),
    .load_data  (load_s),
    .bad        (bad_s)
  );

  // Transaction FSM with registered bus, write-port and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      is_store_r     <= 1'b0;
      funct3_r       <= 3'b000;
      addr_lo_r      <= 2'b00;
      rd_r           <= 5'd0;
      req_ready_r    <= 1'b1;
      done_r         <= 1'b0;
      fault_r        <= 1'b0;
      write_enable_r <= 1'b0;
      write_reg_r    <= 5'd0;
      write_data_r   <= '0;
      mem_valid_r    <= 1'b0;
      mem_write_r    <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      mem_wstrb_r    <= 4'b0000;
    end else begin
      done_r         <= 1'b0;
      fault_r        <= 1'b0;
      write_enable_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            is_store_r  <= req_is_store;
            funct3_r    <= req_funct3;
            addr_lo_r   <= req_addr[1:0];
            rd_r        <= req_rd;
            req_ready_r <= 1'b0;
            if (bad_s) begin
              state_r <= FAULT;
              fault_r <= 1'b1;
              done_r  <= 1'b1;
            end else begin
              state_r     <= REQ;
              mem_valid_r <= 1'b1;
              mem_write_r <= req_is_store;
              mem_addr_r  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata_r <= req_is_store ? wdata_s : '0;
              mem_wstrb_r <= req_is_store ? wstrb_s : 4'b0000;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            mem_valid_r <= 1'b0;
            mem_write_r <= 1'b0;
            mem_wstrb_r <= 4'b0000;
            if (is_store_r) begin
              state_r     <= IDLE;
              done_r      <= 1'b1;
              req_ready_r <= 1'b1;
            end else begin
              state_r <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem.mem_rvalid) begin
            state_r        <= WB;
            write_reg_r    <= rd_r;
            write_data_r   <= load_s;
            write_enable_r <= (rd_r != 5'd0);
            done_r         <= 1'b1;
          end
        end
        WB, FAULT: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_r;
  assign done          = done_r;
  assign fault         = fault_r;
  assign write_enable  = write_enable_r;
  assign write_reg     = write_reg_r;
  assign write_data    = write_data_r;
  assign mem.mem_valid = mem_valid_r;
  assign mem.mem_write = mem_write_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign mem.mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests checked against an arithmetic model of the lane/extension rules.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        done;
  logic        fault;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [4:0]  last_wreg;
  logic [31:0] last_wdata;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_store_data (req_store_data),
    .req_rd         (req_rd),
    .mem            (bus.master),
    .write_enable   (write_enable),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .done           (done),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // One complete request; memory stalls 'stall' cycles and returns data
  // 'rdelay' cycles after the handshake. 'early_rv' pulses a bogus rvalid
  // together with the handshake, which the unit must ignore.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input int stall,
                        input int rdelay, input logic [31:0] rdata, input bit early_rv);
    int          off;
    int          size;
    bit          legal;
    bit          bad;
    logic [31:0] exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic [31:0] mask;

    off = int'(addr % 32'd4);
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    bad = !legal || ((off % size) != 0);

    exp_strb = ((32'd1 << size) - 32'd1) << off;
    case (size)
      1:       exp_wdata = (data & 32'h0000_00FF) * 32'h0101_0101;
      2:       exp_wdata = (data & 32'h0000_FFFF) * 32'h0001_0001;
      default: exp_wdata = data;
    endcase
    exp_load = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      exp_load = exp_load & mask;
      if (!f3[2] && exp_load[8*size-1]) exp_load = exp_load | ~mask;
    end

    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid      = 1'b1;
    req_is_store   = st;
    req_funct3     = f3;
    req_addr       = addr;
    req_store_data = data;
    req_rd         = rd;
    step();
    req_valid      = 1'b0;
    req_store_data = $urandom;
    req_addr       = $urandom;

    if (bad) begin
      check_eq("fault_pulse", {31'd0, fault}, 32'd1);
      check_eq("fault_done", {31'd0, done}, 32'd1);
      check_eq("fault_no_bus", {31'd0, bus.mem_valid}, 32'd0);
      check_eq("fault_no_write", {31'd0, write_enable}, 32'd0);
      check_eq("fault_wreg_hold", {27'd0, write_reg}, {27'd0, last_wreg});
      step();
      check_eq("fault_cleared", {30'd0, fault, done}, 32'd0);
      check_eq("fault_ready", {31'd0, req_ready}, 32'd1);
      return;
    end

    for (int i = 0; i <= stall; i++) begin
      check_eq("mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      check_eq("mem_write", {31'd0, bus.mem_write}, {31'd0, st});
      check_eq("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
      check_eq("mem_wstrb", {28'd0, bus.mem_wstrb}, st ? exp_strb : 32'd0);
      if (st) check_eq("mem_wdata", bus.mem_wdata, exp_wdata);
      check_eq("busy_not_ready", {31'd0, req_ready}, 32'd0);
      check_eq("busy_no_done", {31'd0, done}, 32'd0);
      if (i == stall) begin
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = early_rv;
        bus.mem_rdata  = ~rdata;
      end
      step();
    end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;

    if (st) begin
      check_eq("store_done", {31'd0, done}, 32'd1);
      check_eq("store_bus_idle", {31'd0, bus.mem_valid}, 32'd0);
      check_eq("store_no_write", {31'd0, write_enable}, 32'd0);
      check_eq("store_ready", {31'd0, req_ready}, 32'd1);
      check_eq("store_wdata_hold", write_data, last_wdata);
      step();
      check_eq("store_done_once", {31'd0, done}, 32'd0);
      return;
    end

    check_eq("load_wait_idle_bus", {31'd0, bus.mem_valid}, 32'd0);
    for (int i = 0; i < rdelay; i++) begin
      check_eq("load_wait_no_done", {30'd0, done, write_enable}, 32'd0);
      step();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
    check_eq("wb_enable", {31'd0, write_enable}, {31'd0, (rd != 5'd0)});
    check_eq("wb_reg", {27'd0, write_reg}, {27'd0, rd});
    check_eq("wb_data", write_data, exp_load);
    check_eq("wb_done", {31'd0, done}, 32'd1);
    last_wreg  = rd;
    last_wdata = exp_load;
    step();
    check_eq("after_wb_quiet", {30'd0, done, write_enable}, 32'd0);
    check_eq("after_wb_ready", {31'd0, req_ready}, 32'd1);
    check_eq("after_wb_hold", write_data, last_wdata);
  endtask

  task automatic reset_mid_load();
    check_eq("rst_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0300;
    req_rd       = 5'd7;
    step();
    req_valid     = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check_eq("rst_in_wait", {31'd0, bus.mem_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset          = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_no_done", {30'd0, done, write_enable}, 32'd0);
    check_eq("rst_wreg", {27'd0, write_reg}, 32'd0);
    check_eq("rst_wdata", write_data, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    check_eq("late_rvalid_ignored", {30'd0, done, write_enable}, 32'd0);
    check_eq("late_rvalid_ready", {31'd0, req_ready}, 32'd1);
    last_wreg  = 5'd0;
    last_wdata = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_is_store   = 1'b0;
    req_funct3     = 3'b000;
    req_addr       = 32'd0;
    req_store_data = 32'd0;
    req_rd         = 5'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    last_wreg      = 5'd0;
    last_wdata     = 32'd0;
    step();
    step();
    check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset_flags", {28'd0, done, fault, write_enable, bus.mem_valid}, 32'd0);
    check_eq("reset_bus", {28'd0, bus.mem_wstrb}, 32'd0);
    check_eq("reset_wdata", write_data, 32'd0);
    reset = 1'b0;
    step();

    run_op(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd9, 0, 0, 32'd0, 1'b0);
    run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 0, 32'd0, 1'b0);
    run_op(1'b0, 3'b000, 32'h0000_0202, 32'd0, 5'd5, 0, 0, 32'h1280_3456, 1'b0);
    run_op(1'b0, 3'b100, 32'h0000_0202, 32'd0, 5'd5, 0, 0, 32'h1280_3456, 1'b0);
    run_op(1'b0, 3'b001, 32'h0000_0201, 32'd0, 5'd3, 0, 0, 32'd0, 1'b0);
    run_op(1'b0, 3'b011, 32'h0000_0200, 32'd0, 5'd3, 0, 0, 32'd0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd0, 3, 1, 32'h5555_AAAA, 1'b1);
    run_op(1'b0, 3'b101, 32'h0000_0802, 32'd0, 5'd31, 1, 2, 32'h8001_7FFF, 1'b0);
    run_op(1'b1, 3'b001, 32'h0000_0806, 32'h1234_BEEF, 5'd0, 2, 0, 32'd0, 1'b0);
    reset_mid_load();

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
